// File: rtl/pcap_replay_arbiter.sv
// Packet-granular round-robin arbiter that merges NUM_QUEUES replay AXI streams onto one master.
// A grant is held until the tlast beat is accepted; one idle cycle separates consecutive packets.
module pcap_replay_arbiter #(
  parameter int unsigned C_M_AXIS_DATA_WIDTH  = 256,
  parameter int unsigned C_M_AXIS_TUSER_WIDTH = 128,
  parameter int unsigned NUM_QUEUES           = 4,
  parameter int unsigned CNT_WIDTH            = 32
) (
  input  logic                                              axi_aclk,
  input  logic                                              rst,
  input  logic [NUM_QUEUES*C_M_AXIS_DATA_WIDTH-1:0]         s_axis_tdata,
  input  logic [NUM_QUEUES*C_M_AXIS_DATA_WIDTH/8-1:0]       s_axis_tstrb,
  input  logic [NUM_QUEUES*C_M_AXIS_TUSER_WIDTH-1:0]        s_axis_tuser,
  input  logic [NUM_QUEUES-1:0]                             s_axis_tvalid,
  input  logic [NUM_QUEUES-1:0]                             s_axis_tlast,
  output logic [NUM_QUEUES-1:0]                             s_axis_tready,
  output logic [C_M_AXIS_DATA_WIDTH-1:0]                    m_axis_tdata,
  output logic [C_M_AXIS_DATA_WIDTH/8-1:0]                  m_axis_tstrb,
  output logic [C_M_AXIS_TUSER_WIDTH-1:0]                   m_axis_tuser,
  output logic                                              m_axis_tvalid,
  output logic                                              m_axis_tlast,
  input  logic                                              m_axis_tready,
  input  logic [NUM_QUEUES-1:0]                             queue_en,
  output logic [NUM_QUEUES*CNT_WIDTH-1:0]                   pkt_cnt,
  output logic                                              busy
);

  localparam int unsigned DW = C_M_AXIS_DATA_WIDTH;
  localparam int unsigned SW = C_M_AXIS_DATA_WIDTH / 8;
  localparam int unsigned UW = C_M_AXIS_TUSER_WIDTH;
  localparam int unsigned GW = (NUM_QUEUES > 1) ? $clog2(NUM_QUEUES) : 1;

  typedef enum logic [0:0] {StIdle, StSend} state_e;

  state_e               state_q;
  logic [GW-1:0]        grant_q;
  logic [GW-1:0]        last_grant_q;
  logic [CNT_WIDTH-1:0] cnt_q [NUM_QUEUES];

  logic [NUM_QUEUES-1:0] req;
  logic [GW-1:0]         next_grant;
  logic [GW-1:0]         idx;
  logic                  found;
  logic                  sel_valid;
  logic                  sel_last;
  logic                  pkt_done;

  assign req       = s_axis_tvalid & queue_en;
  assign sel_valid = s_axis_tvalid[grant_q];
  assign sel_last  = s_axis_tlast[grant_q];
  assign pkt_done  = sel_valid & m_axis_tready & sel_last;
  assign busy      = (state_q == StSend);

  // Round-robin search starting just after the last queue that finished a packet.
  always_comb begin
    next_grant = grant_q;
    idx        = '0;
    found      = 1'b0;
    for (int unsigned i = 1; i <= NUM_QUEUES; i++) begin
      idx = GW'((32'(last_grant_q) + i) % NUM_QUEUES);
      if (!found && req[idx]) begin
        next_grant = idx;
        found      = 1'b1;
      end
    end
  end

  always_comb begin
    m_axis_tdata  = '0;
    m_axis_tstrb  = '0;
    m_axis_tuser  = '0;
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    s_axis_tready = '0;
    if (state_q == StSend) begin
      m_axis_tdata  = s_axis_tdata[32'(grant_q)*DW +: DW];
      m_axis_tstrb  = s_axis_tstrb[32'(grant_q)*SW +: SW];
      m_axis_tuser  = s_axis_tuser[32'(grant_q)*UW +: UW];
      m_axis_tvalid = sel_valid;
      m_axis_tlast  = sel_last;
      for (int unsigned q = 0; q < NUM_QUEUES; q++) begin
        s_axis_tready[q] = (grant_q == GW'(q)) ? m_axis_tready : 1'b0;
      end
    end
  end

  always_comb begin
    pkt_cnt = '0;
    for (int unsigned q = 0; q < NUM_QUEUES; q++) begin
      pkt_cnt[q*CNT_WIDTH +: CNT_WIDTH] = cnt_q[q];
    end
  end

  // A reset mid-packet simply drops the grant; no tlast is synthesised for the abandoned packet.
  always_ff @(posedge axi_aclk) begin
    if (rst) begin
      state_q      <= StIdle;
      grant_q      <= '0;
      last_grant_q <= GW'(NUM_QUEUES - 1);
      for (int unsigned q = 0; q < NUM_QUEUES; q++) begin
        cnt_q[q] <= '0;
      end
    end else begin
      unique case (state_q)
        StIdle: begin
          if (|req) begin
            grant_q <= next_grant;
            state_q <= StSend;
          end
        end
        StSend: begin
          if (pkt_done) begin
            cnt_q[grant_q] <= cnt_q[grant_q] + 1'b1;
            last_grant_q   <= grant_q;
            state_q        <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
